// File: rtl/lut_mult_pkg.sv
// Shared constants and types for the radix-4 LUT multiplier.
package lut_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_BITS = 2;

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ndigits);
    return (ndigits > 1) ? $clog2(ndigits) : 1;
  endfunction

endpackage

// File: rtl/lut_mult_accumulator_if.sv
// Operand/result handshake bundle for lut_mult_accumulator.
interface lut_mult_accumulator_if #(
  parameter int unsigned WIDTH = 16
);

  logic                   iValid;
  logic                   oReady;
  logic [WIDTH-1:0]       iData_A;
  logic [WIDTH-1:0]       iData_B;
  logic                   oValid;
  logic                   iAck;
  logic [2*WIDTH-1:0]     oResult;
  logic                   oOverflow;

  modport master (
    output iValid, iData_A, iData_B, iAck,
    input  oReady, oValid, oResult, oOverflow
  );

  modport slave (
    input  iValid, iData_A, iData_B, iAck,
    output oReady, oValid, oResult, oOverflow
  );

endinterface

// File: rtl/two_bit_partial_product.sv
// Combinational 2-bit-digit partial product: 0, A, 2A or 3A.
module two_bit_partial_product #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [1:0]       digit_i,
  output logic [WIDTH+1:0] pp_c
);

  localparam int unsigned PW = WIDTH + 2;

  logic [PW-1:0] a1;
  logic [PW-1:0] a2;
  logic [PW-1:0] a3;

  assign a1 = PW'(a_i);
  assign a2 = a1 << 1;
  assign a3 = a2 + a1;

  always_comb begin
    pp_c = '0;
    unique case (digit_i)
      2'd0: pp_c = '0;
      2'd1: pp_c = a1;
      2'd2: pp_c = a2;
      2'd3: pp_c = a3;
      default: pp_c = '0;
    endcase
  end

endmodule

// File: rtl/lut_mult_accumulator.sv
// Sequential radix-4 multiplier: one 2-bit digit of B per RUN cycle, LSB first.
module lut_mult_accumulator
  import lut_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lut_mult_accumulator_if.slave bus
);

  localparam int unsigned NDIGITS = WIDTH / DIGIT_BITS;
  localparam int unsigned CW      = cnt_width(NDIGITS);
  localparam int unsigned RW      = 2 * WIDTH;
  localparam int unsigned PW      = WIDTH + 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [RW-1:0]    result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    pp;
  logic [RW-1:0]    acc_sum;

  two_bit_partial_product #(.WIDTH(WIDTH)) u_pp (
    .a_i     (a_q),
    .digit_i (b_q[DIGIT_BITS-1:0]),
    .pp_c    (pp)
  );

  // Digit weight is 4^count, i.e. a shift by 2*count.
  assign acc_sum = acc_q + (RW'(pp) << {cnt_q, 1'b0});

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.iValid) begin
          a_d     = bus.iData_A;
          b_d     = bus.iData_B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        b_d   = b_q >> DIGIT_BITS;
        cnt_d = cnt_q + CW'(1);
        // Fixed latency: the last digit is always processed, even if B is exhausted.
        if (cnt_q == CW'(NDIGITS - 1)) begin
          cnt_d    = '0;
          valid_d  = 1'b1;
          result_d = acc_sum;
          ovf_d    = |acc_sum[RW-1:WIDTH];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.iAck) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.oReady    = (state_q == ST_IDLE);
  assign bus.oValid    = valid_q;
  assign bus.oResult   = result_q;
  assign bus.oOverflow = ovf_q;

endmodule
